dqs_preamble_generator: RTL and testbench



---
 rtl/ddr5_dqs_pkg.sv | 62 ++++++
 rtl/dqs_amble_serializer.sv | 46 ++++
 rtl/dqs_preamble_generator.sv | 160 ++++++++++++++++
 tb/tb_dqs_preamble_generator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_dqs_pkg.sv
// Shared DDR5 DQS definitions for the write-side generator and read-side detector.
// Holds the preamble/postamble patterns (left-aligned, MSB first), their lengths and the FSM encoding.
package ddr5_dqs_pkg;

   localparam int AMBLE_W = 9;
   localparam int ALEN_W  = 4;

   typedef struct packed {
      logic [AMBLE_W-1:0] pat;
      logic [ALEN_W-1:0]  len;
   } amble_t;

   localparam logic [AMBLE_W-1:0] PRE_PAT_000 = 9'b10_0000000;
   localparam logic [AMBLE_W-1:0] PRE_PAT_001 = 9'b0010_00000;
   localparam logic [AMBLE_W-1:0] PRE_PAT_010 = 9'b1110_00000;
   localparam logic [AMBLE_W-1:0] PRE_PAT_011 = 9'b000010_000;
   localparam logic [AMBLE_W-1:0] PRE_PAT_100 = 9'b00001010_0;

   localparam logic [ALEN_W-1:0] PRE_LEN_000 = 4'd2;
   localparam logic [ALEN_W-1:0] PRE_LEN_001 = 4'd4;
   localparam logic [ALEN_W-1:0] PRE_LEN_010 = 4'd4;
   localparam logic [ALEN_W-1:0] PRE_LEN_011 = 4'd6;
   localparam logic [ALEN_W-1:0] PRE_LEN_100 = 4'd8;

   localparam logic [AMBLE_W-1:0] POST_PAT_0 = 9'b0_00000000;
   localparam logic [AMBLE_W-1:0] POST_PAT_1 = 9'b010_000000;
   localparam logic [ALEN_W-1:0]  POST_LEN_0 = 4'd1;
   localparam logic [ALEN_W-1:0]  POST_LEN_1 = 4'd3;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_PREAMBLE  = 2'd1;
   localparam logic [1:0] ST_BURST     = 2'd2;
   localparam logic [1:0] ST_POSTAMBLE = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      PREAMBLE  = ST_PREAMBLE,
      BURST     = ST_BURST,
      POSTAMBLE = ST_POSTAMBLE
   } state_t;

   // Reserved encodings 101-111 fall back to the 2-UI preamble.
   function automatic amble_t pre_amble_lookup(input logic [2:0] sett);
      amble_t r;
      case (sett)
         3'b001:  r = '{pat: PRE_PAT_001, len: PRE_LEN_001};
         3'b010:  r = '{pat: PRE_PAT_010, len: PRE_LEN_010};
         3'b011:  r = '{pat: PRE_PAT_011, len: PRE_LEN_011};
         3'b100:  r = '{pat: PRE_PAT_100, len: PRE_LEN_100};
         default: r = '{pat: PRE_PAT_000, len: PRE_LEN_000};
      endcase
      return r;
   endfunction

   function automatic amble_t post_amble_lookup(input logic sett);
      amble_t r;
      if (sett) r = '{pat: POST_PAT_1, len: POST_LEN_1};
      else      r = '{pat: POST_PAT_0, len: POST_LEN_0};
      return r;
   endfunction

endpackage

// File: rtl/dqs_amble_serializer.sv
// Loadable MSB-first shift register with a remaining-UI counter.
// Ports: load_i/tail_i/len_i load a pattern tail; shift_i advances; next_o is the following UI, last_o flags the final UI.
module dqs_amble_serializer #(
   parameter int CNT_W = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [7:0]       tail_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             next_o,
   output logic             last_o
);

   logic [7:0]       sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The head UI of a pattern goes straight into the output flop at load
   // time, so only the tail is held here; cnt counts the current UI too.
   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         sreg_d = tail_i;
         cnt_d  = len_i;
      end else if (shift_i) begin
         sreg_d = {sreg_q[6:0], 1'b0};
         if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

   assign next_o = sreg_q[7];
   assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dqs_preamble_generator.sv
// Write-path DQS generator: preamble, toggling burst window, postamble, one UI per clk_i.
// Ports: start_i + settings in; registered dqs_o, dqs_oe_o, burst_win_o, ready_o, done_o out.
module dqs_preamble_generator
   import ddr5_dqs_pkg::*;
#(
   parameter int BURST_LEN = 16,
   parameter int CHOP_LEN  = 8
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [2:0] pre_amble_sett_i,
   input  logic       post_amble_sett_i,
   input  logic       bl_chop_i,
   output logic       dqs_o,
   output logic       dqs_oe_o,
   output logic       burst_win_o,
   output logic       ready_o,
   output logic       done_o
);

   localparam int CNT_W = $clog2((BURST_LEN > 8) ? BURST_LEN : 8) + 1;
   localparam logic [CNT_W-1:0] BL_FULL = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] BL_CHOP = CNT_W'(CHOP_LEN);

   state_t           state_q, state_d;
   logic             dqs_q, dqs_d;
   logic             oe_q, oe_d;
   logic             bw_q, bw_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             chop_q, chop_d;
   logic             post_q, post_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d;

   amble_t pre_lut, post_lut;
   logic   pre_load, pre_shift, pre_next, pre_last;
   logic   post_load, post_shift, post_next, post_last;

   assign pre_lut  = pre_amble_lookup(pre_amble_sett_i);
   assign post_lut = post_amble_lookup(post_q);

   dqs_amble_serializer #(.CNT_W(CNT_W)) u_pre_ser (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .load_i  (pre_load),
      .shift_i (pre_shift),
      .tail_i  (pre_lut.pat[7:0]),
      .len_i   (CNT_W'(pre_lut.len)),
      .next_o  (pre_next),
      .last_o  (pre_last)
   );

   dqs_amble_serializer #(.CNT_W(CNT_W)) u_post_ser (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .load_i  (post_load),
      .shift_i (post_shift),
      .tail_i  (post_lut.pat[7:0]),
      .len_i   (CNT_W'(post_lut.len)),
      .next_o  (post_next),
      .last_o  (post_last)
   );

   // Every output is the value for the UI after the coming edge, so each
   // phase hands over by computing the first UI of the next phase.
   always_comb begin
      state_d    = state_q;
      dqs_d      = 1'b0;
      oe_d       = 1'b0;
      bw_d       = 1'b0;
      done_d     = 1'b0;
      chop_d     = chop_q;
      post_d     = post_q;
      bcnt_d     = bcnt_q;
      pre_load   = 1'b0;
      pre_shift  = 1'b0;
      post_load  = 1'b0;
      post_shift = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               chop_d   = bl_chop_i;
               post_d   = post_amble_sett_i;
               pre_load = 1'b1;
               state_d  = PREAMBLE;
               dqs_d    = pre_lut.pat[8];
               oe_d     = 1'b1;
            end
         end
         PREAMBLE: begin
            oe_d = 1'b1;
            if (pre_last) begin
               state_d = BURST;
               dqs_d   = 1'b1;
               bw_d    = 1'b1;
               bcnt_d  = chop_q ? BL_CHOP : BL_FULL;
            end else begin
               pre_shift = 1'b1;
               dqs_d     = pre_next;
            end
         end
         BURST: begin
            oe_d = 1'b1;
            if (bcnt_q != '0) bcnt_d = bcnt_q - CNT_W'(1);
            if (bcnt_q == CNT_W'(1)) begin
               state_d   = POSTAMBLE;
               post_load = 1'b1;
               dqs_d     = post_lut.pat[8];
            end else begin
               dqs_d = ~dqs_q;
               bw_d  = 1'b1;
            end
         end
         POSTAMBLE: begin
            if (post_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               oe_d       = 1'b1;
               post_shift = 1'b1;
               dqs_d      = post_next;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         dqs_q   <= 1'b0;
         oe_q    <= 1'b0;
         bw_q    <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         chop_q  <= 1'b0;
         post_q  <= 1'b0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         dqs_q   <= dqs_d;
         oe_q    <= oe_d;
         bw_q    <= bw_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         chop_q  <= chop_d;
         post_q  <= post_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign dqs_o       = dqs_q;
   assign dqs_oe_o    = oe_q;
   assign burst_win_o = bw_q;
   assign ready_o     = ready_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_dqs_preamble_generator.sv
// Self-checking bench for dqs_preamble_generator: per-cycle sequence model plus literal waveforms.
// Ports: none.
module tb_dqs_preamble_generator;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       start_i = 1'b0;
   logic [2:0] pre_amble_sett_i = 3'b000;
   logic       post_amble_sett_i = 1'b0;
   logic       bl_chop_i = 1'b0;
   logic       dqs_o, dqs_oe_o, burst_win_o, ready_o, done_o;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   dqs_preamble_generator #(.BURST_LEN(16), .CHOP_LEN(8)) dut (
      .clk_i             (clk_i),
      .reset_i           (reset_i),
      .start_i           (start_i),
      .pre_amble_sett_i  (pre_amble_sett_i),
      .post_amble_sett_i (post_amble_sett_i),
      .bl_chop_i         (bl_chop_i),
      .dqs_o             (dqs_o),
      .dqs_oe_o          (dqs_oe_o),
      .burst_win_o       (burst_win_o),
      .ready_o           (ready_o),
      .done_o            (done_o)
   );

   always #5 clk_i = ~clk_i;

   // {dqs, oe, bw, done, ready}
   localparam logic [4:0] IDLE_V = 5'b00001;
   logic [4:0] q[$];
   logic [4:0] exp_v = IDLE_V;
   string pre_s[8];

   task automatic push_seq(input logic [2:0] s, input logic p, input logic c);
      string ps;
      string qs;
      int bl;
      ps = pre_s[s];
      qs = p ? "010" : "0";
      bl = c ? 8 : 16;
      for (int i = 0; i < ps.len(); i++)
         q.push_back({ps[i] == "1", 4'b1000});
      for (int i = 0; i < bl; i++)
         q.push_back({(i % 2) == 0, 4'b1100});
      for (int i = 0; i < qs.len(); i++)
         q.push_back({qs[i] == "1", 4'b1000});
      q.push_back(5'b00011);
   endtask

   initial begin
      pre_s = '{"10", "0010", "1110", "000010", "00001010", "10", "10", "10"};
      forever begin
         @(posedge clk_i or posedge reset_i);
         if (reset_i) begin
            q.delete();
            exp_v = IDLE_V;
         end else begin
            if (q.size() == 0 && start_i)
               push_seq(pre_amble_sett_i, post_amble_sett_i, bl_chop_i);
            if (q.size() != 0) exp_v = q.pop_front();
            else exp_v = IDLE_V;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_i);
         if (cmp_en) begin
            checks++;
            if ({dqs_o, dqs_oe_o, burst_win_o, done_o, ready_o} !== exp_v) begin
               errors++;
               $display("FAIL model t=%0t got %b expected %b", $time,
                        {dqs_o, dqs_oe_o, burst_win_o, done_o, ready_o}, exp_v);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, expv);
      end
   endtask

   task automatic fire(input logic [2:0] s, input logic p, input logic c);
      @(posedge clk_i); #2;
      pre_amble_sett_i = s;
      post_amble_sett_i = p;
      bl_chop_i = c;
      start_i = 1'b1;
      @(posedge clk_i); #2;
      start_i = 1'b0;
   endtask

   task automatic capture(input int n, output logic [31:0] dq,
                          output int oe_n, output int bw_n, output int done_at);
      dq = '0; oe_n = 0; bw_n = 0; done_at = 0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk_i);
         dq = {dq[30:0], dqs_o};
         if (dqs_oe_o) oe_n++;
         if (burst_win_o) bw_n++;
         if (done_o && done_at == 0) done_at = k;
      end
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk_i);
         if (done_o) seen = 1'b1;
      end
      chk(name, {31'd0, seen}, 32'd1);
   endtask

   logic [31:0] dq;
   int oe_n, bw_n, done_at;
   logic [7:0] pre_lit[5];
   int pre_len[5];

   initial begin
      pre_lit = '{8'b10, 8'b0010, 8'b1110, 8'b000010, 8'b00001010};
      pre_len = '{2, 4, 4, 6, 8};
      repeat (3) @(posedge clk_i);
      chk("reset_out", {27'd0, dqs_o, dqs_oe_o, burst_win_o, done_o, ready_o}, 32'h1);
      @(posedge clk_i); #2;
      reset_i = 1'b0;
      cmp_en = 1'b1;

      fire(3'b000, 1'b0, 1'b0);
      capture(21, dq, oe_n, bw_n, done_at);
      chk("t1_dqs", dq, {11'd0, 19'b10_1010101010101010_0, 2'b00});
      chk("t1_oe", oe_n, 19);
      chk("t1_bw", bw_n, 16);
      chk("t1_done", done_at, 20);
      chk("t1_ready", {31'd0, ready_o}, 32'd1);

      fire(3'b100, 1'b1, 1'b1);
      capture(21, dq, oe_n, bw_n, done_at);
      chk("t2_dqs", dq, {11'd0, 19'b00001010_10101010_010, 2'b00});
      chk("t2_oe", oe_n, 19);
      chk("t2_bw", bw_n, 8);
      chk("t2_done", done_at, 20);

      fire(3'b111, 1'b0, 1'b0);
      capture(21, dq, oe_n, bw_n, done_at);
      chk("t3_rsvd", dq, {11'd0, 19'b10_1010101010101010_0, 2'b00});
      fire(3'b010, 1'b0, 1'b0);
      capture(23, dq, oe_n, bw_n, done_at);
      chk("t3_010", dq, {9'd0, 21'b1110_1010101010101010_0, 2'b00});
      chk("t3_oe", oe_n, 21);

      fire(3'b000, 1'b0, 1'b0);
      repeat (5) @(posedge clk_i);
      #2;
      start_i = 1'b1;
      pre_amble_sett_i = 3'b100;
      post_amble_sett_i = 1'b1;
      bl_chop_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #2;
      start_i = 1'b0;
      begin
         bit seen;
         seen = 1'b0;
         for (int k = 0; k < 100 && !seen; k++) begin
            @(posedge clk_i); #2;
            if (done_o) seen = 1'b1;
         end
         chk("t4_done_seen", {31'd0, seen}, 32'd1);
      end
      pre_amble_sett_i = 3'b010;
      post_amble_sett_i = 1'b0;
      bl_chop_i = 1'b0;
      start_i = 1'b1;
      @(posedge clk_i); #2;
      start_i = 1'b0;
      @(negedge clk_i);
      chk("t4_b2b", {30'd0, dqs_o, dqs_oe_o}, 32'h3);
      wait_done("t4_b2b_done");

      fire(3'b000, 1'b0, 1'b0);
      repeat (6) @(negedge clk_i);
      chk("t5_inburst", {31'd0, burst_win_o}, 32'd1);
      #1;
      reset_i = 1'b1;
      #1;
      chk("t5_async", {27'd0, dqs_o, dqs_oe_o, burst_win_o, done_o, ready_o}, 32'h1);
      repeat (2) @(posedge clk_i);
      #2;
      reset_i = 1'b0;
      capture(25, dq, oe_n, bw_n, done_at);
      chk("t5_nodone", done_at, 0);

      for (int s = 0; s < 5; s++) begin
         fire(3'(s), 1'b0, 1'b1);
         capture(pre_len[s], dq, oe_n, bw_n, done_at);
         chk($sformatf("t6_detect_%0d", s), dq, {24'd0, pre_lit[s]});
         wait_done($sformatf("t6_done_%0d", s));
      end

      repeat (2) @(posedge clk_i);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
